// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : stall/flush control for the 5-stage RV32 pipeline with
//                    hung-memory watchdog; perf counters via PIPE_HAZARD_PERF_EN
// Rev 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
`ifdef PIPE_HAZARD_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       mem_wb_flush,
  output logic       mem_error
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam logic [15:0] c_mem_timeout = 16'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_nxt;
  logic        r_mem_error;

  logic w_mem_stall;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_branch_flush;

  assign w_mem_stall = dmem_req & ~dmem_ready;
  assign w_rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd);
  assign w_rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd);
  assign w_load_use  = ex_mem_read & (ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 16'd0;
      r_mem_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_state_nxt == ST_ERROR) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  // Watchdog: the >= compare lets ERROR win before the 16-bit counter can wrap.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (!w_mem_stall) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = 16'd0;
        end else if (r_wait_cnt >= c_mem_timeout) begin
          w_state_nxt = ST_ERROR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      ST_ERROR: begin
        w_state_nxt = ST_ERROR;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = 16'd0;
      end
    endcase
  end

  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_stall   = 1'b0;
    mem_wb_flush   = 1'b0;
    w_branch_flush = 1'b0;
    if (!rst) begin
      if ((r_state == ST_ERROR) || w_mem_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_branch_taken) begin
        // The ID instruction is squashed, so any load-use on it is moot.
        w_branch_flush = 1'b1;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
      end else if (w_load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign mem_error = r_mem_error;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_branch_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_branch_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, mem_error}
  localparam logic [7:0] C_IDLE   = 8'b0000_0000;
  localparam logic [7:0] C_LDUSE  = 8'b1100_1000;
  localparam logic [7:0] C_BRANCH = 8'b0010_1000;
  localparam logic [7:0] C_FREEZE = 8'b1101_0110;
  localparam logic [7:0] C_ERROR  = 8'b1101_0111;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       dmem_req, dmem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_flush, mem_error;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  logic [7:0] ctl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
    .mem_error(mem_error)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                id_ex_flush, ex_mem_stall, mem_wb_flush, mem_error};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic mem_cycle(input logic ready, input logic br, input logic [7:0] exp, input string tag);
    dmem_req = 1'b1; dmem_ready = ready; ex_branch_taken = br;
    #1 check(tag, ctl, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2 check("reset_idle", ctl, C_IDLE);
    dmem_req = 1'b1; ex_branch_taken = 1'b1;
    #1 check("reset_forces_zero", ctl, C_IDLE);
    tick(); tick();
    idle_inputs();
    rst = 1'b0;
    #1 check("after_reset_idle", ctl, C_IDLE);
`ifdef PIPE_HAZARD_PERF_EN
    check("perf_stall_reset", stall_cycles, 32'd0);
    check("perf_flush_reset", flush_count, 32'd0);
`endif
    tick();

    // Load-use via rs2, then with x0 destination
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1 check("lu_rs2", ctl, C_LDUSE);
    tick();
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #1 check("lu_x0", ctl, C_IDLE);
    tick();
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    #1 check("lu_rs1", ctl, C_LDUSE);
    id_uses_rs1 = 1'b0;
    #1 check("lu_rs1_unused", ctl, C_IDLE);
    ex_mem_read = 1'b0; id_uses_rs1 = 1'b1;
    #1 check("no_load", ctl, C_IDLE);
    tick();

    // Branch coincident with load-use
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; ex_branch_taken = 1'b1;
    #1 check("branch_over_lu", ctl, C_BRANCH);
    tick();
`ifdef PIPE_HAZARD_PERF_EN
    check("perf_flush_one", flush_count, 32'd1);
`endif
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    tick();

    // Three-cycle memory wait
    for (int i = 0; i < 3; i++) mem_cycle(1'b0, 1'b0, C_FREEZE, "mem_wait");
    dmem_ready = 1'b1;
    #1 check("mem_ready", ctl, C_IDLE);
    tick();
`ifdef PIPE_HAZARD_PERF_EN
    check("perf_stall_three", stall_cycles, 32'd3);
`endif
    idle_inputs();
    #1 check("mem_back_run", ctl, C_IDLE);
    tick();

    // Branch held back by memory wait
    for (int i = 0; i < 2; i++) mem_cycle(1'b0, 1'b1, C_FREEZE, "branch_in_wait");
    mem_cycle(1'b1, 1'b1, C_BRANCH, "branch_at_ready");
    idle_inputs();

    // Ready arrives in the last tolerated wait cycle
    for (int i = 0; i < TIMEOUT; i++) mem_cycle(1'b0, 1'b0, C_FREEZE, "edge_wait");
    mem_cycle(1'b1, 1'b0, C_IDLE, "edge_ready");
    idle_inputs();
    #1 check("edge_no_error", ctl, C_IDLE);
    tick();

    // Timeout: one RUN cycle plus TIMEOUT MEM_WAIT cycles, then ERROR
    for (int i = 0; i < TIMEOUT + 1; i++) mem_cycle(1'b0, 1'b0, C_FREEZE, "timeout_wait");
    #1 check("timeout_error", ctl, C_ERROR);
    idle_inputs();
    ex_branch_taken = 1'b1;
    #1 check("error_absorbs", ctl, C_ERROR);
    tick();
    #1 check("error_sticky", ctl, C_ERROR);
    #2 rst = 1'b1;
    #1 check("error_async_clear", ctl, C_IDLE);
    tick();
    rst = 1'b0;
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    #1 check("run_after_error", ctl, C_LDUSE);
    tick();
    idle_inputs();

    // Async reset mid-wait clears the watchdog counter
    for (int i = 0; i < 3; i++) mem_cycle(1'b0, 1'b0, C_FREEZE, "pre_reset_wait");
    #2 rst = 1'b1;
    #1 check("midwait_async", ctl, C_IDLE);
`ifdef PIPE_HAZARD_PERF_EN
    check("midwait_perf_clear", stall_cycles, 32'd0);
`endif
    tick();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < TIMEOUT + 1; i++) mem_cycle(1'b0, 1'b0, C_FREEZE, "post_reset_wait");
    #1 check("post_reset_timeout", ctl, C_ERROR);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
